// File: rtl/text_console_ctrl_if.sv
// Video-card character-buffer bus: single outstanding access, STB/ACK handshake.
// The controller is the master; the card (or its model) is the slave.
interface text_console_ctrl_if;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK;

  modport master (
    output STB,
    output WE,
    output ADDR,
    output DAT_O,
    input  DAT_I,
    input  ACK
  );

  modport slave (
    input  STB,
    input  WE,
    input  ADDR,
    input  DAT_O,
    output DAT_I,
    output ACK
  );
endinterface

// File: rtl/text_console_ctrl.sv
// Console sequencer: turns a putchar byte stream into character-buffer writes,
// tracking the cursor and doing CR/LF/BS/FF, hardware scroll and clear.
module text_console_ctrl #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  ATTR  = 8'h00,
  parameter logic [15:0] BLANK = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       char_valid,
  input  logic [7:0]                 char_data,
  output logic                       char_ready,
  text_console_ctrl_if.master        bus,
  output logic [6:0]                 cursor_x,
  output logic [4:0]                 cursor_y,
  output logic                       busy
);

  localparam logic [11:0] L_COLS     = 12'(COLS);
  localparam logic [11:0] L_LAST     = 12'(COLS * ROWS - 1);
  localparam logic [11:0] L_LAST_ROW = 12'((ROWS - 1) * COLS);
  localparam logic [6:0]  L_XMAX     = 7'(COLS - 1);
  localparam logic [4:0]  L_YMAX     = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_ERASE,
    S_SCROLL_RD,
    S_SCROLL_WR,
    S_FILL,
    S_CLEAR
  } state_t;

  state_t      r_state;
  logic        r_char_ready;
  logic        r_stb;
  logic        r_we;
  logic [11:0] r_addr;
  logic [15:0] r_dat;
  logic [11:0] r_idx;       // scroll source index, or fill/clear index
  logic [15:0] r_rd;        // cell captured by the last scroll read
  logic [7:0]  r_char;
  logic [6:0]  r_cursor_x;
  logic [4:0]  r_cursor_y;

  logic [11:0] w_cell_addr;
  logic [11:0] w_acc_addr;
  logic [15:0] w_acc_dat;
  logic        w_acc_we;
  logic        w_unused_dat_hi;

  assign w_cell_addr     = 12'(r_cursor_y) * L_COLS + 12'(r_cursor_x);
  assign w_unused_dat_hi = ^bus.DAT_I[31:16];

  // Address/data/direction of the access the current state wants to issue.
  always_comb begin
    w_acc_addr = r_idx;
    w_acc_dat  = BLANK;
    w_acc_we   = 1'b1;
    case (r_state)
      S_PUT: begin
        w_acc_addr = w_cell_addr;
        w_acc_dat  = {ATTR, r_char};
      end
      S_ERASE:     w_acc_addr = w_cell_addr;
      S_SCROLL_RD: w_acc_we   = 1'b0;
      S_SCROLL_WR: begin
        w_acc_addr = r_idx - L_COLS;
        w_acc_dat  = r_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_char_ready <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 12'd0;
      r_dat        <= 16'd0;
      r_idx        <= 12'd0;
      r_rd         <= 16'd0;
      r_char       <= 8'd0;
      r_cursor_x   <= 7'd0;
      r_cursor_y   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_char_ready <= 1'b1;
          if (char_valid && r_char_ready) begin
            case (char_data)
              8'h0D: r_cursor_x <= 7'd0;
              8'h0A: begin
                r_cursor_x <= 7'd0;
                if (r_cursor_y != L_YMAX) begin
                  r_cursor_y <= r_cursor_y + 5'd1;
                end else begin
                  r_idx        <= L_COLS;
                  r_state      <= S_SCROLL_RD;
                  r_char_ready <= 1'b0;
                end
              end
              8'h08: begin
                // Backspace stops at column 0; it never wraps to the previous row.
                if (r_cursor_x != 7'd0) begin
                  r_cursor_x   <= r_cursor_x - 7'd1;
                  r_state      <= S_ERASE;
                  r_char_ready <= 1'b0;
                end
              end
              8'h0C: begin
                r_idx        <= 12'd0;
                r_state      <= S_CLEAR;
                r_char_ready <= 1'b0;
              end
              default: begin
                r_char       <= char_data;
                r_state      <= S_PUT;
                r_char_ready <= 1'b0;
              end
            endcase
          end
        end

        default: begin
          // Raise only once the card has released ACK from the previous access.
          if (!r_stb) begin
            if (!bus.ACK) begin
              r_stb  <= 1'b1;
              r_we   <= w_acc_we;
              r_addr <= w_acc_addr;
              r_dat  <= w_acc_dat;
            end
          end else if (bus.ACK) begin
            r_stb <= 1'b0;
            case (r_state)
              S_PUT: begin
                if (r_cursor_x == L_XMAX) begin
                  r_cursor_x <= 7'd0;
                  if (r_cursor_y == L_YMAX) begin
                    r_idx   <= L_COLS;
                    r_state <= S_SCROLL_RD;
                  end else begin
                    r_cursor_y   <= r_cursor_y + 5'd1;
                    r_state      <= S_IDLE;
                    r_char_ready <= 1'b1;
                  end
                end else begin
                  r_cursor_x   <= r_cursor_x + 7'd1;
                  r_state      <= S_IDLE;
                  r_char_ready <= 1'b1;
                end
              end
              S_ERASE: begin
                r_state      <= S_IDLE;
                r_char_ready <= 1'b1;
              end
              S_SCROLL_RD: begin
                r_rd    <= bus.DAT_I[15:0];
                r_state <= S_SCROLL_WR;
              end
              S_SCROLL_WR: begin
                if (r_idx == L_LAST) begin
                  r_idx   <= L_LAST_ROW;
                  r_state <= S_FILL;
                end else begin
                  r_idx   <= r_idx + 12'd1;
                  r_state <= S_SCROLL_RD;
                end
              end
              S_FILL, S_CLEAR: begin
                if (r_idx == L_LAST) begin
                  if (r_state == S_CLEAR) begin
                    r_cursor_x <= 7'd0;
                    r_cursor_y <= 5'd0;
                  end
                  r_state      <= S_IDLE;
                  r_char_ready <= 1'b1;
                end else begin
                  r_idx <= r_idx + 12'd1;
                end
              end
              default: begin
                r_state      <= S_IDLE;
                r_char_ready <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.STB    = r_stb;
  assign bus.WE     = r_we;
  assign bus.ADDR   = {20'd0, r_addr};
  assign bus.DAT_O  = {16'd0, r_dat};
  assign char_ready = r_char_ready;
  assign cursor_x   = r_cursor_x;
  assign cursor_y   = r_cursor_y;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a registered-ACK card model,
// a bus transaction log and a handshake protocol monitor.
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  text_console_ctrl_if vbus ();

  text_console_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .bus        (vbus),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Card model: ACK registered, optional wait states, held while STB is held.
  logic [15:0] mem [0:2399];
  logic        ack_r = 1'b0;
  logic [31:0] dati_r = 32'd0;
  int          stall_cycles = 0;
  int          wait_cnt = 0;

  assign vbus.ACK   = ack_r;
  assign vbus.DAT_I = dati_r;

  always @(posedge clk) begin
    if (vbus.STB && !ack_r) begin
      if (wait_cnt >= stall_cycles) begin
        ack_r <= 1'b1;
        if (vbus.ADDR < 32'd2400) begin
          if (vbus.WE) mem[vbus.ADDR[11:0]] = vbus.DAT_O[15:0];
          else dati_r <= {16'h0000, mem[vbus.ADDR[11:0]]};
        end
        wait_cnt = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else if (!vbus.STB) begin
      ack_r <= 1'b0;
      wait_cnt = 0;
    end
  end

  // Transaction log and protocol monitor, sampled on the falling edge.
  logic        log_we   [0:4999];
  logic [31:0] log_addr [0:4999];
  logic [15:0] log_dat  [0:4999];
  int          log_n = 0;
  int          stb_hi = 0;
  int          proto_err = 0;
  logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_dat = 32'd0;

  always @(negedge clk) begin
    if (vbus.STB) stb_hi = stb_hi + 1;
    if (vbus.STB && vbus.ACK && log_n < 5000) begin
      log_we[log_n]   = vbus.WE;
      log_addr[log_n] = vbus.ADDR;
      log_dat[log_n]  = vbus.WE ? vbus.DAT_O[15:0] : vbus.DAT_I[15:0];
      log_n = log_n + 1;
    end
    if (!reset) begin
      if (p_stb && !p_ack && vbus.STB &&
          (vbus.ADDR != p_addr || vbus.DAT_O != p_dat || vbus.WE != p_we))
        proto_err = proto_err + 1;
      if (p_stb && p_ack && vbus.STB) proto_err = proto_err + 1;
      if (!p_stb && vbus.STB && p_ack) proto_err = proto_err + 1;
    end
    p_stb  = vbus.STB;
    p_ack  = vbus.ACK;
    p_we   = vbus.WE;
    p_addr = vbus.ADDR;
    p_dat  = vbus.DAT_O;
  end

  int   n_checks = 0;
  int   n_fail = 0;
  logic ready_after_accept = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (!char_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!char_ready) check_eq("ready_timeout", {31'd0, char_ready}, 32'd1);
    char_valid = 1'b1;
    char_data  = b;
    @(negedge clk);
    char_valid = 1'b0;
    ready_after_accept = char_ready;
    t = 0;
    while ((busy || !char_ready) && t < 25000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 25000) check_eq("idle_timeout", {30'd0, busy, char_ready}, 32'd1);
    $display("byte 0x%02h -> cursor=(%0d,%0d) bus_ops=%0d", b, cursor_x, cursor_y, log_n);
  endtask

  initial begin
    int bad;
    int t;
    for (int i = 0; i < 2400; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_stb", {31'd0, vbus.STB}, 32'd0);
    check_eq("rst_we", {31'd0, vbus.WE}, 32'd0);
    check_eq("rst_addr", vbus.ADDR, 32'd0);
    check_eq("rst_dato", vbus.DAT_O, 32'd0);
    check_eq("rst_ready", {31'd0, char_ready}, 32'd0);
    check_eq("rst_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("rst_cy", {27'd0, cursor_y}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, char_ready}, 32'd1);

    // Single printable byte
    log_n = 0;
    send_byte(8'h41);
    check_eq("A_ready_low", {31'd0, ready_after_accept}, 32'd0);
    check_eq("A_ops", log_n, 32'd1);
    check_eq("A_we", {31'd0, log_we[0]}, 32'd1);
    check_eq("A_addr", log_addr[0], 32'd0);
    check_eq("A_dat", {16'd0, log_dat[0]}, 32'h41);
    check_eq("A_dato32", vbus.DAT_O, 32'h0000_0041);
    check_eq("A_cx", {25'd0, cursor_x}, 32'd1);
    check_eq("A_cy", {27'd0, cursor_y}, 32'd0);

    // Full row with wrap to the next row
    do_reset();
    log_n = 0;
    for (int i = 0; i < 80; i++) send_byte(8'(8'h20 + i));
    bad = 0;
    for (int i = 0; i < 80; i++)
      if (log_we[i] !== 1'b1 || log_addr[i] !== 32'(i) || log_dat[i] !== 16'(8'h20 + i)) bad++;
    check_eq("row_ops", log_n, 32'd80);
    check_eq("row_bad", bad, 32'd0);
    check_eq("row_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("row_cy", {27'd0, cursor_y}, 32'd1);
    check_eq("row_mem79", {16'd0, mem[79]}, 32'h6F);

    // Scroll on LF at the last row
    do_reset();
    log_n = 0;
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    check_eq("lf_cy", {27'd0, cursor_y}, 32'd29);
    check_eq("lf_noops", log_n, 32'd0);
    mem[80]   = 16'h0042;
    mem[2350] = 16'hBEEF;
    mem[2399] = 16'h1234;
    log_n = 0;
    send_byte(8'h0A);
    check_eq("scr_ops", log_n, 32'd4720);
    check_eq("scr_rd0_we", {31'd0, log_we[0]}, 32'd0);
    check_eq("scr_rd0_addr", log_addr[0], 32'd80);
    check_eq("scr_rd0_dat", {16'd0, log_dat[0]}, 32'h42);
    check_eq("scr_wr0_we", {31'd0, log_we[1]}, 32'd1);
    check_eq("scr_wr0_addr", log_addr[1], 32'd0);
    check_eq("scr_wr0_dat", {16'd0, log_dat[1]}, 32'h42);
    check_eq("scr_wrlast_addr", log_addr[4639], 32'd2319);
    check_eq("scr_wrlast_dat", {16'd0, log_dat[4639]}, 32'h1234);
    check_eq("scr_fill0_addr", log_addr[4640], 32'd2320);
    check_eq("scr_filln_addr", log_addr[4719], 32'd2399);
    check_eq("scr_mem2270", {16'd0, mem[2270]}, 32'hBEEF);
    bad = 0;
    for (int i = 2320; i < 2400; i++) if (mem[i] !== 16'h0000) bad++;
    check_eq("scr_fill_bad", bad, 32'd0);
    check_eq("scr_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("scr_cy", {27'd0, cursor_y}, 32'd29);
    check_eq("scr_busy", {31'd0, busy}, 32'd0);

    // Form feed clears the whole buffer in ascending order
    send_byte(8'h78);
    check_eq("ff_pre_mem", {16'd0, mem[2320]}, 32'h78);
    log_n = 0;
    send_byte(8'h0C);
    check_eq("ff_ops", log_n, 32'd2400);
    bad = 0;
    for (int i = 0; i < 2400; i++)
      if (log_we[i] !== 1'b1 || log_addr[i] !== 32'(i) || log_dat[i] !== 16'h0000) bad++;
    check_eq("ff_bad", bad, 32'd0);
    check_eq("ff_mem2320", {16'd0, mem[2320]}, 32'd0);
    check_eq("ff_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("ff_cy", {27'd0, cursor_y}, 32'd0);

    // Backspace, and backspace at column 0
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i));
    check_eq("bs_pre_cx", {25'd0, cursor_x}, 32'd5);
    log_n = 0;
    send_byte(8'h08);
    check_eq("bs_ops", log_n, 32'd1);
    check_eq("bs_addr", log_addr[0], 32'd244);
    check_eq("bs_dat", {16'd0, log_dat[0]}, 32'd0);
    check_eq("bs_cx", {25'd0, cursor_x}, 32'd4);
    check_eq("bs_cy", {27'd0, cursor_y}, 32'd3);
    send_byte(8'h0D);
    check_eq("cr_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("cr_ops", log_n, 32'd1);
    log_n = 0;
    send_byte(8'h08);
    check_eq("bs0_ops", log_n, 32'd0);
    check_eq("bs0_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("bs0_cy", {27'd0, cursor_y}, 32'd3);

    // Reset in the middle of a scroll
    do_reset();
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    char_valid = 1'b1;
    char_data  = 8'h0A;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (40) @(negedge clk);
    t = 0;
    while (!vbus.STB && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_stb_high", {31'd0, vbus.STB}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_stb_drop", {31'd0, vbus.STB}, 32'd0);
    check_eq("mid_ready", {31'd0, char_ready}, 32'd0);
    check_eq("mid_cx", {25'd0, cursor_x}, 32'd0);
    check_eq("mid_cy", {27'd0, cursor_y}, 32'd0);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_ready_after", {31'd0, char_ready}, 32'd1);
    log_n = 0;
    send_byte(8'h5A);
    check_eq("Z_ops", log_n, 32'd1);
    check_eq("Z_addr", log_addr[0], 32'd0);
    check_eq("Z_dat", {16'd0, log_dat[0]}, 32'h5A);

    // Wait-stated write: STB held through the stall, single strobe
    stall_cycles = 5;
    log_n  = 0;
    stb_hi = 0;
    send_byte(8'h51);
    stall_cycles = 0;
    check_eq("stall_stb_cycles", stb_hi, 32'd7);
    check_eq("stall_ops", log_n, 32'd1);
    check_eq("stall_addr", log_addr[0], 32'd1);
    check_eq("stall_dat", {16'd0, log_dat[0]}, 32'h51);
    check_eq("proto_errors", proto_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Bus-master sequencer that turns a byte stream (putchar-style) into cell writes on the 80x30 text-mode video card's 16-bit character buffer.
- Owns the cursor and handles CR, LF, backspace and form-feed.
- Performs hardware scroll (row copy plus last-row blank) and full-screen clear through the card's STB/ACK/WE/ADDR/DAT bus.
- Sits between the CPU-side console port and the video card, so software never touches buffer addresses directly.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- ATTR, 8'h00, upper byte written with every printable character.
- BLANK, 16'h0000, cell value used for clear, scroll fill and backspace erase.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- char_valid  input  1  upstream byte offered.
- char_data  input  8  byte value.
- char_ready  output  1  controller can accept a byte this cycle.
- STB  output  1  bus strobe to video card.
- WE  output  1  write enable (1 = write, 0 = read).
- ADDR  output  32  cell index 0..COLS*ROWS-1; upper bits are 0.
- DAT_O  output  32  write data; bits [15:0] are the cell, [31:16] are 0.
- DAT_I  input  32  read data from card; valid while ACK=1.
- ACK  input  1  card acknowledge.
- cursor_x  output  7  current column, 0..COLS-1.
- cursor_y  output  5  current row, 0..ROWS-1.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: STB=0, WE=0, ADDR=0, DAT_O=0, char_ready=0 in the reset cycle, cursor_x=0, cursor_y=0, busy=0, state=IDLE.
- Reset does not clear the buffer.
- Reset mid-operation aborts immediately: STB drops the next edge and any in-flight copy is abandoned.

Bus rule:
- Raise STB with ADDR/WE/DAT_O stable, and hold them until ACK=1 is sampled.
- Drop STB the cycle after ACK=1 is sampled.
- Do not raise STB again until ACK=0 is sampled. The card's ACK is registered and stays high while STB is held.
- Minimum 3 cycles per access.
- Read data is captured from DAT_I[15:0] in the cycle ACK=1.

Acceptance:
- char_ready = 1 only in IDLE.
- A byte is accepted when char_valid && char_ready at a clock edge; state leaves IDLE the next cycle.

States:
- IDLE: wait for a byte and decode it.
  - 0x0D -> col=0, stay IDLE, no bus access.
  - 0x0A -> col=0; if row<ROWS-1 then row++ and IDLE, else SCROLL_RD with src=COLS, dst=0.
  - 0x08 -> if col>0: col--, then ERASE. At col=0, no-op (no wrap to previous row).
  - 0x0C -> CLEAR with idx=0, then cursor (0,0).
  - Any other byte -> PUT.
- PUT: write {ATTR,char} at row*COLS+col. On completion col++. If col reaches COLS: col=0 and row++; if row would reach ROWS, enter SCROLL_RD with row held at ROWS-1.
- ERASE: write BLANK at the new cursor position, then IDLE.
- SCROLL_RD: read cell src.
- SCROLL_WR: write the captured value to dst=src-COLS, then src++. If src==COLS*ROWS, go to FILL with idx=(ROWS-1)*COLS; else SCROLL_RD.
- FILL: write BLANK at idx, idx++, up to COLS*ROWS-1, then IDLE.
- CLEAR: write BLANK at idx 0..COLS*ROWS-1, then IDLE.

Arithmetic:
- Address = row*COLS+col computed in 12 bits; max 2399 fits.
- src/idx counters are 12 bits.
- cursor_x/cursor_y update only at the completion points above. They never show COLS or ROWS.
- Full scroll = 2320 read+write pairs plus 80 fills.

Test Plan:
- Reset, send 'A' (0x41) -> one write: ADDR=0, WE=1, DAT_O=0x00000041; cursor_x=1, cursor_y=0; char_ready low until the bus cycle completes.
- Send 80 printable bytes from (0,0) -> writes to ADDR 0..79; cursor ends at (0,1); no scroll.
- Preload card cell 80=0x0042; put cursor at row 29; send 0x0A -> a read at ADDR 80 is followed by a write of 0x0042 to ADDR 0; cells 2320..2399 written BLANK; cursor (0,29); busy high throughout, low after.
- Send 0x0C after writing text -> 2400 writes of 0x0000 to addresses 0..2399 in ascending order; cursor (0,0).
- At (5,3) send 0x08 -> write BLANK to ADDR 244; cursor (4,3). At (0,3) send 0x08 -> no bus activity, cursor unchanged.
- Assert reset mid-scroll with STB high -> STB=0 the next cycle, cursor (0,0), char_ready=1 one cycle after reset is released; a new 'Z' (0x5A) then writes to ADDR 0.
- Hold ACK low 5 cycles on a write -> STB, ADDR and DAT_O stay stable throughout; no second strobe until ACK returns to 0.
